rr_mux_arb: RTL and testbench
=============================

Name: rr_mux_arb

Overview:
- Parametrised, registered N-channel, W-bit arbitrating multiplexer with valid/ready handshakes; generalises the team's 1-bit 2:1 mux primitive.
- Sits in front of the queue: merges several producer streams into one stream feeding the queue's write port.
- Selection is made by an internal arbiter: round-robin or fixed-priority, with optional packet locking.
- Output is registered with a one-word holding stage.

Parameters:
- DATA_WIDTH, 8, bits per data word.
- NUM_CH, 4, number of input channels (2..16).
- SEL_WIDTH, 2, width of channel index; must satisfy 2^SEL_WIDTH >= NUM_CH.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- PKT_LOCK, 1, 1 = grant held until a beat with last set is accepted; 0 = re-arbitrate every beat.

Ports:
- clk_i  input  1  clock, all logic on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- in_data_i  input  NUM_CH*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_valid_i  input  NUM_CH  per-channel word valid.
- in_last_i  input  NUM_CH  per-channel end-of-packet flag, qualified by in_valid_i.
- in_ready_o  output  NUM_CH  per-channel accept; one-hot or zero.
- out_data_o  output  DATA_WIDTH  registered selected word.
- out_valid_o  output  1  out_data_o holds a word.
- out_last_o  output  1  registered last flag of held word.
- out_ch_o  output  SEL_WIDTH  index of channel that supplied held word.
- out_ready_i  input  1  downstream (queue) accept.

Behaviour:
- Reset (rst_i high at clock edge): out_valid_o=0, out_data_o=0, out_last_o=0, out_ch_o=0, lock cleared, round-robin pointer = NUM_CH-1 (so ch0 has first priority).
- While rst_i is high, in_ready_o=0 regardless of inputs.
- Reset mid-packet discards the held word and the lock; no partial state survives.
- load_en = !out_valid_o | out_ready_i.
- in_ready_o[g] = load_en & grant[g] & in_valid_i[g]. in_ready_o is combinational from in_valid_i, lock state and pointer only, never from out_data_o.
- Grant with lock active: grant = locked channel only. Other channels wait even if the locked channel is idle.
- Grant in round-robin mode, unlocked: first requesting channel searching from pointer+1 upward, wrapping at NUM_CH-1 to 0.
- Grant in fixed-priority mode, unlocked: lowest-index requesting channel.
- No requests: grant=0, nothing loaded.
- Transfer on channel g (in_valid_i[g] & in_ready_o[g]), at next edge:
  - out_data_o <= channel g data; out_last_o <= in_last_i[g]; out_ch_o <= g; out_valid_o <= 1.
  - Round-robin pointer <= g.
  - If PKT_LOCK=1 and in_last_i[g]=0: lock set to g.
  - If in_last_i[g]=1: lock cleared.
- Output accepted (out_ready_i=1) with no new transfer: out_valid_o <= 0. out_data_o, out_last_o and out_ch_o retain their values.
- Simultaneous output accept and new load: the new word replaces the old in the same edge, giving 1 word/cycle sustained throughput.
- Backpressure (out_valid_o=1, out_ready_i=0): all outputs hold stable, in_ready_o all 0, pointer and lock unchanged.
- Latency: exactly 1 cycle from input acceptance to out_valid_o.
- No word is duplicated or dropped. Per-channel order is preserved.
- With PKT_LOCK=0, in_last_i is passed through to out_last_o only and does not affect the lock.
- NUM_CH not a power of two: indices >= NUM_CH are never granted. The pointer wraps at NUM_CH-1.

Test Plan:
- Reset: drive all in_valid_i=1, rst_i=1 for 2 cycles -> in_ready_o=0, out_valid_o=0, out_data_o=0, out_ch_o=0. First grant after release = ch0.
- Round-robin fairness: ARB_MODE=0, PKT_LOCK=0, all 4 channels valid with data 8'hA0+k, out_ready_i=1 -> out_ch_o sequence 0,1,2,3,0,1, one word per cycle, data matches channel.
- Fixed priority: ARB_MODE=1, ch1 and ch3 valid continuously -> only ch1 served. Deassert ch1 -> ch3 served next cycle.
- Packet lock: PKT_LOCK=1, ch2 sends a 3-beat packet (last on beat 3) while ch0 is continuously valid -> out_ch_o = 2,2,2, then 0. ch0 in_ready_o=0 throughout the packet.
- Backpressure: out_ready_i=0 for 5 cycles with a word held -> out_data_o, out_last_o and out_ch_o stable, all in_ready_o=0. Release -> transfer resumes with no loss or duplication.
- Reset mid-packet: assert rst_i after beat 1 of a ch1 packet while ch0 is valid -> after reset, lock cleared and ch0 is granted first.

Source files
------------

// File: rtl/rr_mux_arb.sv
// N-channel arbitrating multiplexer with valid/ready handshakes and a registered
// one-word output stage; round-robin or fixed-priority grant with optional packet lock.
module rr_mux_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int ARB_MODE   = 0,
  parameter int PKT_LOCK   = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data_i,
  input  logic [NUM_CH-1:0]            in_valid_i,
  input  logic [NUM_CH-1:0]            in_last_i,
  output logic [NUM_CH-1:0]            in_ready_o,
  output logic [DATA_WIDTH-1:0]        out_data_o,
  output logic                         out_valid_o,
  output logic                         out_last_o,
  output logic [SEL_WIDTH-1:0]         out_ch_o,
  input  logic                         out_ready_i
);

  localparam int unsigned NCH = NUM_CH;

  typedef enum logic {
    LOCK_OPEN,
    LOCK_HELD
  } lock_state_e;

  lock_state_e            lock_st_q, lock_st_d;
  logic [SEL_WIDTH-1:0]   lock_ch_q, lock_ch_d;
  logic [SEL_WIDTH-1:0]   ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic [SEL_WIDTH-1:0]   out_ch_q, out_ch_d;

  logic [NUM_CH-1:0]      grant;
  logic [NUM_CH-1:0]      ready;
  logic                   load_en;
  logic                   found;
  int unsigned            cand;

  // Grant already includes the request bit, so an idle locked channel yields no grant
  // while still blocking every other channel.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = 0;
    if (lock_st_q == LOCK_HELD) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (SEL_WIDTH'(k) == lock_ch_q) grant[k] = in_valid_i[k];
      end
    end else if (ARB_MODE == 1) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (!found && in_valid_i[k]) begin
          grant[k] = 1'b1;
          found    = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 1; i <= NCH; i++) begin
        cand = 32'(ptr_q) + i;
        if (cand >= NCH) cand = cand - NCH;
        for (int unsigned k = 0; k < NCH; k++) begin
          if (!found && (k == cand) && in_valid_i[k]) begin
            grant[k] = 1'b1;
            found    = 1'b1;
          end
        end
      end
    end
  end

  assign load_en = !out_valid_q || out_ready_i;
  assign ready   = (load_en && !rst_i) ? grant : '0;

  always_comb begin
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    lock_st_d   = lock_st_q;
    lock_ch_d   = lock_ch_q;
    if (|ready) begin
      out_valid_d = 1'b1;
      for (int unsigned k = 0; k < NCH; k++) begin
        if (ready[k]) begin
          out_data_d = in_data_i[k*DATA_WIDTH +: DATA_WIDTH];
          out_last_d = in_last_i[k];
          out_ch_d   = SEL_WIDTH'(k);
          ptr_d      = SEL_WIDTH'(k);
          if (in_last_i[k]) begin
            lock_st_d = LOCK_OPEN;
          end else if (PKT_LOCK != 0) begin
            lock_st_d = LOCK_HELD;
            lock_ch_d = SEL_WIDTH'(k);
          end
        end
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SEL_WIDTH'(NUM_CH - 1);
      lock_st_q   <= LOCK_OPEN;
      lock_ch_q   <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
      lock_st_q   <= lock_st_d;
      lock_ch_q   <= lock_ch_d;
    end
  end

  assign in_ready_o  = ready;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_ch_o    = out_ch_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb: round-robin, fixed-priority, packet-lock and
// 3-channel instances sharing one clock and reset.
module tb_rr_mux_arb;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // round-robin, no lock
  logic [31:0] rr_data;
  logic [3:0]  rr_valid, rr_last, rr_rdy;
  logic [7:0]  rr_od;
  logic        rr_ov, rr_ol, rr_ordy;
  logic [1:0]  rr_och;
  // fixed priority, no lock
  logic [31:0] fp_data;
  logic [3:0]  fp_valid, fp_last, fp_rdy;
  logic [7:0]  fp_od;
  logic        fp_ov, fp_ol, fp_ordy;
  logic [1:0]  fp_och;
  // round-robin with packet lock
  logic [31:0] lk_data;
  logic [3:0]  lk_valid, lk_last, lk_rdy;
  logic [7:0]  lk_od;
  logic        lk_ov, lk_ol, lk_ordy;
  logic [1:0]  lk_och;
  // three channels, round-robin
  logic [23:0] n3_data;
  logic [2:0]  n3_valid, n3_last, n3_rdy;
  logic [7:0]  n3_od;
  logic        n3_ov, n3_ol, n3_ordy;
  logic [1:0]  n3_och;

  rr_mux_arb #(.DATA_WIDTH(8), .NUM_CH(4), .SEL_WIDTH(2), .ARB_MODE(0), .PKT_LOCK(0)) u_rr (
    .clk_i(clk), .rst_i(rst), .in_data_i(rr_data), .in_valid_i(rr_valid), .in_last_i(rr_last),
    .in_ready_o(rr_rdy), .out_data_o(rr_od), .out_valid_o(rr_ov), .out_last_o(rr_ol),
    .out_ch_o(rr_och), .out_ready_i(rr_ordy));

  rr_mux_arb #(.DATA_WIDTH(8), .NUM_CH(4), .SEL_WIDTH(2), .ARB_MODE(1), .PKT_LOCK(0)) u_fp (
    .clk_i(clk), .rst_i(rst), .in_data_i(fp_data), .in_valid_i(fp_valid), .in_last_i(fp_last),
    .in_ready_o(fp_rdy), .out_data_o(fp_od), .out_valid_o(fp_ov), .out_last_o(fp_ol),
    .out_ch_o(fp_och), .out_ready_i(fp_ordy));

  rr_mux_arb #(.DATA_WIDTH(8), .NUM_CH(4), .SEL_WIDTH(2), .ARB_MODE(0), .PKT_LOCK(1)) u_lk (
    .clk_i(clk), .rst_i(rst), .in_data_i(lk_data), .in_valid_i(lk_valid), .in_last_i(lk_last),
    .in_ready_o(lk_rdy), .out_data_o(lk_od), .out_valid_o(lk_ov), .out_last_o(lk_ol),
    .out_ch_o(lk_och), .out_ready_i(lk_ordy));

  rr_mux_arb #(.DATA_WIDTH(8), .NUM_CH(3), .SEL_WIDTH(2), .ARB_MODE(0), .PKT_LOCK(0)) u_n3 (
    .clk_i(clk), .rst_i(rst), .in_data_i(n3_data), .in_valid_i(n3_valid), .in_last_i(n3_last),
    .in_ready_o(n3_rdy), .out_data_o(n3_od), .out_valid_o(n3_ov), .out_last_o(n3_ol),
    .out_ch_o(n3_och), .out_ready_i(n3_ordy));

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_ch;
    logic [7:0] exp_data;
    logic       exp_last;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Applies one cycle on the lock instance; channel 2 data is per-beat.
  task automatic lk_step(input string nm, input logic [3:0] v, input logic [3:0] l,
                         input logic [7:0] d2, input logic ordy, input logic [3:0] er,
                         input logic ev, input logic [1:0] ech, input logic [7:0] ed,
                         input logic el);
    lk_valid = v;
    lk_last  = l;
    lk_data  = {8'hC3, d2, 8'hC1, 8'hC0};
    lk_ordy  = ordy;
    #1;
    chk({nm, ".rdy"}, 32'(lk_rdy), 32'(er));
    @(posedge clk);
    #1;
    chk({nm, ".ov"}, 32'(lk_ov), 32'(ev));
    chk({nm, ".ch"}, 32'(lk_och), 32'(ech));
    chk({nm, ".data"}, 32'(lk_od), 32'(ed));
    chk({nm, ".last"}, 32'(lk_ol), 32'(el));
  endtask

  task automatic fp_step(input string nm, input logic [3:0] v, input logic [3:0] er,
                         input logic [1:0] ech, input logic [7:0] ed);
    fp_valid = v;
    #1;
    chk({nm, ".rdy"}, 32'(fp_rdy), 32'(er));
    @(posedge clk);
    #1;
    chk({nm, ".ov"}, 32'(fp_ov), 32'd1);
    chk({nm, ".ch"}, 32'(fp_och), 32'(ech));
    chk({nm, ".data"}, 32'(fp_od), 32'(ed));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    tbl[0]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0, 1'b0};
    tbl[1]  = '{4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1, 1'b0};
    tbl[2]  = '{4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2, 1'b0};
    tbl[3]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3, 1'b0};
    tbl[4]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0, 1'b0};
    tbl[5]  = '{4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1, 1'b0};
    tbl[6]  = '{4'b0101, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2, 1'b1};
    tbl[7]  = '{4'b0101, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA2, 1'b1};
    tbl[8]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA2, 1'b1};
    tbl[9]  = '{4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 8'hA3, 1'b1};
    tbl[10] = '{4'b1001, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3, 8'hA3, 1'b1};
    tbl[11] = '{4'b1001, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0, 1'b0};
    tbl[12] = '{4'b1001, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3, 1'b0};

    rr_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    fp_data = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    lk_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    n3_data = {8'hD2, 8'hD1, 8'hD0};
    rr_valid = 4'hF; fp_valid = 4'hF; lk_valid = 4'hF; n3_valid = 3'h7;
    rr_last  = '0;   fp_last  = '0;   lk_last  = '0;   n3_last  = '0;
    rr_ordy  = 1'b1; fp_ordy  = 1'b1; lk_ordy  = 1'b1; n3_ordy  = 1'b1;
    rst = 1'b1;

    // reset with every channel requesting
    #1;
    chk("rst.rr_rdy", 32'(rr_rdy), 32'd0);
    chk("rst.lk_rdy", 32'(lk_rdy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rr_rdy2", 32'(rr_rdy), 32'd0);
    chk("rst.fp_rdy", 32'(fp_rdy), 32'd0);
    chk("rst.rr_ov", 32'(rr_ov), 32'd0);
    chk("rst.rr_data", 32'(rr_od), 32'd0);
    chk("rst.rr_ch", 32'(rr_och), 32'd0);
    chk("rst.rr_last", 32'(rr_ol), 32'd0);
    chk("rst.lk_ov", 32'(lk_ov), 32'd0);
    rst = 1'b0;
    fp_valid = '0; lk_valid = '0; n3_valid = '0;

    // table-driven round-robin sequence
    for (int i = 0; i < 13; i++) begin
      rr_valid = tbl[i].valid;
      rr_last  = tbl[i].last;
      rr_ordy  = tbl[i].ordy;
      #1;
      chk($sformatf("rr[%0d].rdy", i), 32'(rr_rdy), 32'(tbl[i].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("rr[%0d].ov", i), 32'(rr_ov), 32'(tbl[i].exp_ov));
      chk($sformatf("rr[%0d].ch", i), 32'(rr_och), 32'(tbl[i].exp_ch));
      chk($sformatf("rr[%0d].data", i), 32'(rr_od), 32'(tbl[i].exp_data));
      chk($sformatf("rr[%0d].last", i), 32'(rr_ol), 32'(tbl[i].exp_last));
    end
    rr_valid = '0;

    // fixed priority: ch1 beats ch3 until it drops, all-valid picks ch0
    fp_step("fp0", 4'b1010, 4'b0010, 2'd1, 8'hB1);
    fp_step("fp1", 4'b1010, 4'b0010, 2'd1, 8'hB1);
    fp_step("fp2", 4'b1010, 4'b0010, 2'd1, 8'hB1);
    fp_step("fp3", 4'b1000, 4'b1000, 2'd3, 8'hB3);
    fp_step("fp4", 4'b1111, 4'b0001, 2'd0, 8'hB0);
    fp_valid = '0;

    // three channels: pointer wraps at 2
    n3_valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("n3[%0d].rdy", i), 32'(n3_rdy), 32'd1 << (i % 3));
      @(posedge clk);
      #1;
      chk($sformatf("n3[%0d].ch", i), 32'(n3_och), 32'(i % 3));
      chk($sformatf("n3[%0d].data", i), 32'(n3_od), 32'hD0 + 32'(i % 3));
    end
    n3_valid = '0;

    // packet lock: ch2 3-beat packet with ch0 waiting, incl. an idle beat mid-packet
    lk_step("lk0", 4'b0010, 4'b0010, 8'hC2, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hC1, 1'b1);
    lk_step("lk1", 4'b0101, 4'b0000, 8'h21, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h21, 1'b0);
    lk_step("lk2", 4'b0101, 4'b0000, 8'h22, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h22, 1'b0);
    lk_step("lk3", 4'b0001, 4'b0000, 8'h22, 1'b1, 4'b0000, 1'b0, 2'd2, 8'h22, 1'b0);
    lk_step("lk4", 4'b0101, 4'b0100, 8'h23, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h23, 1'b1);
    lk_step("lk5", 4'b0001, 4'b0001, 8'h23, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hC0, 1'b1);

    // backpressure: five stalled cycles, then release without loss or duplication
    for (int i = 0; i < 5; i++) begin
      lk_step($sformatf("bp%0d", i), 4'b0101, 4'b0101, 8'h24, 1'b0, 4'b0000,
              1'b1, 2'd0, 8'hC0, 1'b1);
    end
    lk_step("bp_rel0", 4'b0101, 4'b0101, 8'h24, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h24, 1'b1);
    lk_step("bp_rel1", 4'b0001, 4'b0001, 8'h24, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hC0, 1'b1);
    lk_step("bp_idle", 4'b0000, 4'b0000, 8'h24, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hC0, 1'b1);

    // reset after beat 1 of a ch1 packet, ch0 also requesting
    lk_step("mr0", 4'b0010, 4'b0000, 8'h24, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hC1, 1'b0);
    rst = 1'b1;
    lk_valid = 4'b0011;
    #1;
    chk("mr.rdy_in_rst", 32'(lk_rdy), 32'd0);
    @(posedge clk);
    #1;
    chk("mr.ov", 32'(lk_ov), 32'd0);
    chk("mr.data", 32'(lk_od), 32'd0);
    chk("mr.ch", 32'(lk_och), 32'd0);
    rst = 1'b0;
    lk_step("mr1", 4'b0011, 4'b0000, 8'h24, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hC0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
